// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch definitions: FSM state encodings, error codes, default reset PC.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_timeout_cnt.sv
// Fetch wait counter: pulses expired on the TIMEOUT-th consecutive enabled cycle.
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires during the last allowed wait cycle so the FSM leaves on that edge.
    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer with req/ack memory handshake.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      nPC,
    input  logic             npc_load,
    output logic [31:0]      PC,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] fetch_cnt
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         wait_en;
    logic         wait_clr;
    logic         expired;
    logic         npc_ok;

    assign npc_ok   = is_aligned(nPC);
    assign wait_en  = (state_q == S_REQ) && !im_ack;
    assign wait_clr = (state_q != S_REQ);

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (wait_en),
        .clear   (wait_clr),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (im_ack) begin
                    state_d = S_HOLD;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                if (npc_load) begin
                    state_d = npc_ok ? S_REQ : S_ERR;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Request is decoded from the registered state so reset kills it at once.
    always_comb begin
        im_req  = (state_q == S_REQ);
        im_addr = PC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            fetch_cnt   <= '0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (im_ack) begin
                        instr       <= im_rdata;
                        instr_valid <= 1'b1;
                    end else if (expired) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                S_HOLD: begin
                    if (npc_load) begin
                        instr_valid <= 1'b0;
                        if (npc_ok) begin
                            PC        <= nPC;
                            fetch_cnt <= fetch_cnt + 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_MISALIGN;
                        end
                    end
                end
                S_ERR: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nPC;
    logic        npc_load;
    logic [31:0] PC;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] fetch_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (16),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nPC         (nPC),
        .npc_load    (npc_load),
        .PC          (PC),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .err         (err),
        .err_code    (err_code),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        npc_load = 1'b0;
        im_ack   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        logic [31:0] e;
        chk("fetch_req", {31'd0, im_req}, 32'd1);
        chk("fetch_addr", im_addr, exp_addr);
        im_ack   = 1'b1;
        im_rdata = data;
        exp_q.push_back(data);
        tick();
        im_ack = 1'b0;
        chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
        chk("sb_depth", exp_q.size(), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("fetch_instr", instr, e);
    endtask

    task automatic load(input logic [31:0] npc);
        npc_load = 1'b1;
        nPC      = npc;
        tick();
        npc_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        rst      = 1'b1;
        nPC      = '0;
        npc_load = 1'b0;
        im_ack   = 1'b0;
        im_rdata = '0;
        #2;
        chk("rst_pc", PC, 32'h3000);
        chk("rst_req", {31'd0, im_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        do_reset();

        // Sequential fetch, 1-cycle ack
        pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            fetch(pc, 32'h0000_0013 + (i << 8));
            load(pc + 32'd4);
            chk("seq_valid_low", {31'd0, instr_valid}, 32'd0);
            pc = pc + 32'd4;
            chk("seq_pc", PC, pc);
        end
        chk("seq_cnt", {16'd0, fetch_cnt}, 32'd3);
        fetch(32'h300C, 32'h1111_0001);
        load(32'h3010);
        chk("cnt4", {16'd0, fetch_cnt}, 32'd4);

        // Jump
        fetch(32'h3010, 32'h2222_0002);
        load(32'h3400);
        chk("jmp_pc", PC, 32'h3400);
        chk("jmp_addr", im_addr, 32'h3400);
        chk("jmp_cnt", {16'd0, fetch_cnt}, 32'd5);

        // npc_load in S_REQ and spurious ack in S_HOLD are ignored
        npc_load = 1'b1;
        nPC      = 32'h5000;
        tick();
        npc_load = 1'b0;
        chk("ign_load_pc", PC, 32'h3400);
        chk("ign_load_cnt", {16'd0, fetch_cnt}, 32'd5);
        fetch(32'h3400, 32'hAAAA_5555);
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        chk("spur_instr", instr, 32'hAAAA_5555);
        chk("spur_valid", {31'd0, instr_valid}, 32'd1);
        chk("spur_pc", PC, 32'h3400);

        // Misaligned target
        load(32'h3402);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_code", {30'd0, err_code}, 32'd1);
        chk("mis_pc", PC, 32'h3400);
        chk("mis_req", {31'd0, im_req}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_cnt", {16'd0, fetch_cnt}, 32'd5);
        im_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky_req", {31'd0, im_req}, 32'd0);
            chk("err_sticky_code", {30'd0, err_code}, 32'd1);
        end
        im_ack = 1'b0;

        // Reset mid-handshake
        do_reset();
        chk("r2_req", {31'd0, im_req}, 32'd1);
        chk("r2_err", {31'd0, err}, 32'd0);
        chk("r2_cnt", {16'd0, fetch_cnt}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'd0, im_req}, 32'd0);
        chk("async_pc", PC, 32'h3000);
        im_ack   = 1'b1;
        im_rdata = 32'hBAD0_BAD0;
        tick();
        rst = 1'b0;
        tick();
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        chk("refetch_req", {31'd0, im_req}, 32'd1);
        im_ack = 1'b0;
        fetch(32'h3000, 32'h3333_0003);
        load(32'h3004);

        // Ack on the 16th wait cycle wins over timeout
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wait_req", {31'd0, im_req}, 32'd1);
            chk("wait_err", {31'd0, err}, 32'd0);
        end
        fetch(32'h3004, 32'h4444_0004);
        chk("ack16_err", {31'd0, err}, 32'd0);
        load(32'h3008);

        // No ack for 16 cycles -> timeout
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait_req", {31'd0, im_req}, 32'd1);
        end
        tick();
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_code", {30'd0, err_code}, 32'd2);
        chk("to_req", {31'd0, im_req}, 32'd0);
        chk("to_valid", {31'd0, instr_valid}, 32'd0);
        chk("to_pc", PC, 32'h3008);
        chk("to_cnt", {16'd0, fetch_cnt}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
